// File: rtl/multimode_ff_bank.sv
// multimode_ff_bank
// Bank of WIDTH clocked flip-flops sharing a run-time mode select.
// Each bit acts as an S-R, J-K, D or T flip-flop. The bank also provides a
// clock enable, a synchronous active-low reset, and illegal-input tracking:
// S=R=1 in SR mode sets a sticky per-bit ILLEGAL flag and bumps a saturating
// event counter. Every output is registered or derived only from registers,
// so no input reaches an output without passing through a flop.

module multimode_ff_bank #(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 EN,
  input  logic [1:0]           MODE,
  input  logic [WIDTH-1:0]     S,
  input  logic [WIDTH-1:0]     R,
  input  logic                 CLR_ERR,
  output logic [WIDTH-1:0]     Q,
  output logic [WIDTH-1:0]     Q_prim,
  output logic [WIDTH-1:0]     ILLEGAL,
  output logic [ERR_CNT_W-1:0] ERR_CNT,
  output logic                 CHANGED
);

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_t;

  mode_t            mode;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] illegal_now;
  logic             any_illegal;
  logic             err_cnt_sat;

  assign mode        = mode_t'(MODE);
  assign any_illegal = |illegal_now;
  assign err_cnt_sat = &ERR_CNT;

  // Complement output comes straight from the state register.
  assign Q_prim = ~Q;

  // Next-state and illegal-event decode for all bits in the selected mode.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    q_next      = Q;
    illegal_now = '0;
    if (EN) begin
      unique case (mode)
        // 00 hold, 10 set, 01 clear, 11 hold (flagged as illegal)
        MODE_SR: begin
          q_next      = (S & ~R) | (Q & ~(S ^ R));
          illegal_now = S & R;
        end
        // 00 hold, 10 set, 01 clear, 11 toggle
        MODE_JK: q_next = (S & ~Q) | (~R & Q);
        MODE_D:  q_next = S;
        MODE_T:  q_next = Q ^ S;
        default: q_next = Q;
      endcase
    end
  end

  // State register and change pulse; EN gates all updates.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!RST_N) begin
      Q       <= '0;
      CHANGED <= 1'b0;
    end else if (EN) begin
      Q       <= q_next;
      CHANGED <= |(q_next ^ Q);
    end else begin
      CHANGED <= 1'b0;
    end
  end

  // Sticky illegal flags and saturating counter. CLR_ERR acts even with
  // EN=0; a new illegal event in the clearing cycle wins over the clear.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ILLEGAL <= '0;
      ERR_CNT <= '0;
    end else if (CLR_ERR) begin
      ILLEGAL <= illegal_now;
      ERR_CNT <= any_illegal ? ERR_CNT_W'(1) : '0;
    end else begin
      ILLEGAL <= ILLEGAL | illegal_now;
      if (any_illegal && !err_cnt_sat) begin
        ERR_CNT <= ERR_CNT + ERR_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_multimode_ff_bank.sv
// Testbench for multimode_ff_bank with WIDTH=4, ERR_CNT_W=2.
// Directed scenarios check fixed expected values; a randomized phase compares
// every output against a bit-level behavioural model each cycle.

module tb_multimode_ff_bank;

  localparam int WIDTH     = 4;
  localparam int ERR_CNT_W = 2;
  localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;

  logic                 clk;
  logic                 rst_n;
  logic                 en;
  logic [1:0]           mode;
  logic [WIDTH-1:0]     s;
  logic [WIDTH-1:0]     r;
  logic                 clr_err;
  logic [WIDTH-1:0]     q;
  logic [WIDTH-1:0]     q_prim;
  logic [WIDTH-1:0]     illegal;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 changed;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] m_ill;
  int               m_cnt;
  logic             m_chg;

  multimode_ff_bank #(.WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W)) dut (
    .CLK     (clk),
    .RST_N   (rst_n),
    .EN      (en),
    .MODE    (mode),
    .S       (s),
    .R       (r),
    .CLR_ERR (clr_err),
    .Q       (q),
    .Q_prim  (q_prim),
    .ILLEGAL (illegal),
    .ERR_CNT (err_cnt),
    .CHANGED (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the behavioural model by one edge using the current inputs.
  task automatic model_edge();
    logic [WIDTH-1:0] qn;
    logic [WIDTH-1:0] ill_now;
    qn      = m_q;
    ill_now = '0;
    if (!rst_n) begin
      m_q   = '0;
      m_ill = '0;
      m_cnt = 0;
      m_chg = 1'b0;
      return;
    end
    if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        case (mode)
          2'd0: begin
            if (s[i] && r[i])      ill_now[i] = 1'b1;
            else if (s[i])         qn[i] = 1'b1;
            else if (r[i])         qn[i] = 1'b0;
          end
          2'd1: begin
            if (s[i] && r[i])      qn[i] = !m_q[i];
            else if (s[i])         qn[i] = 1'b1;
            else if (r[i])         qn[i] = 1'b0;
          end
          2'd2: qn[i] = s[i];
          default: if (s[i]) qn[i] = !m_q[i];
        endcase
      end
      m_chg = (qn != m_q);
      m_q   = qn;
    end else begin
      m_chg = 1'b0;
    end
    if (clr_err) begin
      m_ill = ill_now;
      m_cnt = (ill_now != 0) ? 1 : 0;
    end else begin
      m_ill = m_ill | ill_now;
      if (ill_now != 0 && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end
  endtask

  // One rising edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [1:0] md,
                       input logic [WIDTH-1:0] sv, input logic [WIDTH-1:0] rv,
                       input logic clr);
    en = e; mode = md; s = sv; r = rv; clr_err = clr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 2'd0, 4'hF, 4'hF, 1'b0);
    tick();
    tick();
    checks += 5;
    if (q !== 4'h0)       begin failures++; $display("FAIL reset_q got=%h exp=0", q); end
    if (q_prim !== 4'hF)  begin failures++; $display("FAIL reset_qprim got=%h exp=f", q_prim); end
    if (illegal !== 4'h0) begin failures++; $display("FAIL reset_ill got=%h exp=0", illegal); end
    if (err_cnt !== 2'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", err_cnt); end
    if (changed !== 1'b0) begin failures++; $display("FAIL reset_chg got=%b exp=0", changed); end
    rst_n = 1'b1;
  endtask

  task automatic test_sr();
    logic [WIDTH-1:0] sv [3];
    logic [WIDTH-1:0] rv [3];
    logic [WIDTH-1:0] eq [3];
    logic             ec [3];
    sv = '{4'h1, 4'h0, 4'h0};
    rv = '{4'h0, 4'h0, 4'h1};
    eq = '{4'h1, 4'h1, 4'h0};
    ec = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2'd0, sv[k], rv[k], 1'b0);
      tick();
      checks += 3;
      if (q !== eq[k])       begin failures++; $display("FAIL sr_q[%0d] got=%h exp=%h", k, q, eq[k]); end
      if (changed !== ec[k]) begin failures++; $display("FAIL sr_chg[%0d] got=%b exp=%b", k, changed, ec[k]); end
      if (q_prim !== ~eq[k]) begin failures++; $display("FAIL sr_qprim[%0d] got=%h exp=%h", k, q_prim, ~eq[k]); end
    end
  endtask

  task automatic test_sr_illegal();
    logic [ERR_CNT_W-1:0] ecnt [4];
    ecnt = '{2'd1, 2'd2, 2'd3, 2'd3};
    drive(1'b1, 2'd0, 4'h1, 4'h0, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'd0, 4'h3, 4'h3, 1'b0);
      tick();
      checks += 3;
      if (q !== 4'h1)         begin failures++; $display("FAIL ill_q[%0d] got=%h exp=1", k, q); end
      if (illegal !== 4'h3)   begin failures++; $display("FAIL ill_flags[%0d] got=%h exp=3", k, illegal); end
      if (err_cnt !== ecnt[k]) begin failures++; $display("FAIL ill_cnt[%0d] got=%0d exp=%0d", k, err_cnt, ecnt[k]); end
    end
    drive(1'b1, 2'd0, 4'h4, 4'h4, 1'b1);
    tick();
    checks += 3;
    if (illegal !== 4'h4) begin failures++; $display("FAIL clr_new_ill got=%h exp=4", illegal); end
    if (err_cnt !== 2'd1) begin failures++; $display("FAIL clr_new_cnt got=%0d exp=1", err_cnt); end
    if (q !== 4'h1)       begin failures++; $display("FAIL clr_new_q got=%h exp=1", q); end
    clr_err = 1'b0;
  endtask

  task automatic test_jk();
    logic [WIDTH-1:0] eq [3];
    eq = '{4'hA, 4'h0, 4'hA};
    drive(1'b1, 2'd0, 4'h0, 4'hF, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2'd1, 4'hA, 4'hA, 1'b0);
      tick();
      checks += 3;
      if (q !== eq[k])      begin failures++; $display("FAIL jk_q[%0d] got=%h exp=%h", k, q, eq[k]); end
      if (changed !== 1'b1) begin failures++; $display("FAIL jk_chg[%0d] got=%b exp=1", k, changed); end
      if (illegal !== 4'h4) begin failures++; $display("FAIL jk_ill[%0d] got=%h exp=4", k, illegal); end
    end
  endtask

  task automatic test_clr_no_en();
    drive(1'b0, 2'd0, 4'hF, 4'hF, 1'b1);
    tick();
    checks += 3;
    if (illegal !== 4'h0) begin failures++; $display("FAIL clr_noen_ill got=%h exp=0", illegal); end
    if (err_cnt !== 2'd0) begin failures++; $display("FAIL clr_noen_cnt got=%0d exp=0", err_cnt); end
    if (q !== 4'hA)       begin failures++; $display("FAIL clr_noen_q got=%h exp=a", q); end
    clr_err = 1'b0;
  endtask

  task automatic test_d_t_en();
    logic [1:0]       md [4];
    logic [WIDTH-1:0] sv [4];
    logic             ev [4];
    logic [WIDTH-1:0] eq [4];
    logic             ec [4];
    md = '{2'd2, 2'd3, 2'd3, 2'd3};
    sv = '{4'h6, 4'h3, 4'h3, 4'hF};
    ev = '{1'b1, 1'b1, 1'b1, 1'b0};
    eq = '{4'h6, 4'h5, 4'h6, 4'h6};
    ec = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      drive(ev[k], md[k], sv[k], 4'h0, 1'b0);
      tick();
      checks += 2;
      if (q !== eq[k])       begin failures++; $display("FAIL dt_q[%0d] got=%h exp=%h", k, q, eq[k]); end
      if (changed !== ec[k]) begin failures++; $display("FAIL dt_chg[%0d] got=%b exp=%b", k, changed, ec[k]); end
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 2'd3, 4'hF, 4'h0, 1'b0);
    tick();
    checks++;
    if (q !== 4'h9) begin failures++; $display("FAIL mr_toggle got=%h exp=9", q); end
    drive(1'b1, 2'd0, 4'h1, 4'h1, 1'b0);
    tick();
    drive(1'b1, 2'd3, 4'hF, 4'h0, 1'b0);
    rst_n = 1'b0;
    tick();
    checks += 3;
    if (q !== 4'h0)       begin failures++; $display("FAIL mr_q got=%h exp=0", q); end
    if (err_cnt !== 2'd0) begin failures++; $display("FAIL mr_cnt got=%0d exp=0", err_cnt); end
    if (illegal !== 4'h0) begin failures++; $display("FAIL mr_ill got=%h exp=0", illegal); end
    rst_n = 1'b1;
    tick();
    checks += 2;
    if (q !== 4'hF)       begin failures++; $display("FAIL mr_resume_q got=%h exp=f", q); end
    if (changed !== 1'b1) begin failures++; $display("FAIL mr_resume_chg got=%b exp=1", changed); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst_n   = ($urandom_range(0, 29) != 0);
      en      = ($urandom_range(0, 4) != 0);
      mode    = 2'($urandom_range(0, 3));
      s       = 4'($urandom);
      r       = 4'($urandom);
      clr_err = ($urandom_range(0, 9) == 0);
      tick();
      checks++;
      if (q !== m_q || q_prim !== ~m_q || illegal !== m_ill ||
          err_cnt !== ERR_CNT_W'(m_cnt) || changed !== m_chg) begin
        failures++;
        $display("FAIL rand[%0d] got q=%h qp=%h ill=%h cnt=%0d chg=%b exp q=%h qp=%h ill=%h cnt=%0d chg=%b",
                 k, q, q_prim, illegal, err_cnt, changed, m_q, ~m_q, m_ill, m_cnt, m_chg);
      end
    end
  endtask

  initial begin
    m_q = '0; m_ill = '0; m_cnt = 0; m_chg = 1'b0;
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 4'h0, 4'h0, 1'b0);
    #2;
    test_reset();
    test_sr();
    test_sr_illegal();
    test_jk();
    test_clr_no_en();
    test_d_t_en();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multimode_ff_bank.md
# multimode_ff_bank

Parametrised bank of WIDTH clocked flip-flops with a shared run-time mode select. It is the next generation of the team's single-bit clocked S-R latch. Each bit behaves as an S-R, J-K, D or T flip-flop, and the bank adds synchronous reset, a clock enable and illegal-input (S=R=1) detection with a sticky flag and a saturating error counter. It is the generic storage primitive for later sequential examples such as counters, shift registers and small FSMs.

## Interface
Parameters:
- WIDTH, 8, number of flip-flop bits (≥1)
- ERR_CNT_W, 4, width of the saturating illegal-event counter (≥1)

Ports:
- CLK  in  1  clock; all state changes on the rising edge
- RST_N  in  1  reset, synchronous, active-low; sampled on the rising CLK edge
- EN  in  1  clock enable; 0 = hold all state except CLR_ERR effects
- MODE  in  2  00 = SR, 01 = JK, 10 = D, 11 = T; applies to all bits
- S  in  WIDTH  per bit: S (SR mode), J (JK mode), D (D mode) or T (T mode)
- R  in  WIDTH  per bit: R (SR mode) or K (JK mode); ignored in D and T modes
- CLR_ERR  in  1  synchronous clear of ILLEGAL and ERR_CNT
- Q  out  WIDTH  flip-flop state
- Q_prim  out  WIDTH  complement of Q (~Q), combinational from the Q register
- ILLEGAL  out  WIDTH  sticky per-bit flag: S=R=1 was seen on that bit in SR mode
- ERR_CNT  out  ERR_CNT_W  saturating count of cycles with ≥1 illegal bit
- CHANGED  out  1  registered pulse: Q changed on the last edge

## Operation
- Reset (RST_N=0 at an edge) sets Q=0 (so Q_prim = all ones), ILLEGAL=0, ERR_CNT=0 and CHANGED=0.
- Reset overrides EN, CLR_ERR and MODE. Reset in the middle of a sequence discards all state at that edge.
- EN=0: Q holds, CHANGED<=0, and no illegal detection occurs.
- EN=1, per-bit next state (q = current bit):
  - SR mode, S,R: 00 hold; 10 set; 01 clear; 11 hold q and set ILLEGAL[i].
  - JK mode, J,K: 00 hold; 10 set; 01 clear; 11 toggle. No illegal detection.
  - D mode: q <= S[i].
  - T mode: q <= q ^ S[i].
- MODE is sampled at every edge. A mode change takes effect at the same edge; no state is lost across a mode change.
- ERR_CNT increments by 1 per edge with EN=1, MODE=SR and any bit at S=R=1. It saturates at 2^ERR_CNT_W−1 and never wraps.
- ILLEGAL bits stay set until CLR_ERR or reset.
- CLR_ERR=1 clears ILLEGAL and ERR_CNT at the edge. If an illegal condition occurs in the same cycle, the new event wins: the affected ILLEGAL bits become 1 and ERR_CNT becomes 1.
- CLR_ERR works regardless of EN.
- CHANGED <= |(Q_next ^ Q) at each edge with EN=1.

## Timing
- One-edge latency for every registered output: Q, ILLEGAL, ERR_CNT and CHANGED update at the edge that samples their inputs.
- Q_prim follows Q combinationally, with no extra cycle. Q_prim == ~Q at all times after the first edge.
- No combinational path from any input to any output.
- Inputs need setup and hold only around the rising CLK edge. Input glitches between edges have no effect.

## Test plan
- WIDTH=4, ERR_CNT_W=2. Hold RST_N=0 for 2 edges with S=R=4'hF and CLR_ERR=0 → Q=0000, Q_prim=1111, ILLEGAL=0, ERR_CNT=0, CHANGED=0.
- SR mode, EN=1, apply in turn S/R=0001/0000, 0000/0000, 0000/0001 → Q=0001, then 0001 (CHANGED=0), then 0000 (CHANGED=1).
- SR mode, S=R=0011 for 4 edges with Q=0001 beforehand → Q stays 0001, ILLEGAL=0011, ERR_CNT=1,2,3,3 (saturates). Then CLR_ERR=1 with S=R=0100 → ILLEGAL=0100, ERR_CNT=1.
- JK mode, J=K=1010 for 3 edges starting from Q=0000 → Q=1010, 0000, 1010, with CHANGED=1 each edge and ILLEGAL unchanged.
- D mode with S=0110, then T mode with S=0011 for 2 edges, then EN=0 with S=1111 → Q=0110, 0101, 0110, then held at 0110 with CHANGED=0.
- Mid-run reset: T mode with S=1111 toggling; assert RST_N=0 together with CLR_ERR=0 → at that edge Q=0000 and ERR_CNT=0. Toggling resumes on the first edge after RST_N=1.
